packet_buffer_ingress_arbiter: RTL

Packet-granular round-robin arbiter that shares the single AXI4-Stream ingress of packet_buffer between NUM_PORTS capture interfaces. It locks a grant for a whole packet (tlast to tlast) and tags every beat with the source interface id. It also enforces a maximum packet length by truncating oversize packets and draining the remainder. It sits directly upstream of packet_buffer; its master port drives the buffer's tdata/tvalid/tready/tlast/tkeep inputs.

---
 rtl/packet_buffer_ingress_arbiter_if.sv | 29 ++
 rtl/packet_buffer_ingress_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/packet_buffer_ingress_arbiter_if.sv
// Stream bundle between the capture ports, the ingress arbiter and packet_buffer.
// master = arbiter side (drives the merged stream and the per-port readies), slave = environment side.
interface packet_buffer_ingress_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int AXI_WIDTH = 64,
    parameter int ID_W      = $clog2(NUM_PORTS)
);
    logic [NUM_PORTS-1:0][AXI_WIDTH-1:0]   s_tdata_i;
    logic [NUM_PORTS-1:0][AXI_WIDTH/8-1:0] s_tkeep_i;
    logic [NUM_PORTS-1:0]                  s_tlast_i;
    logic [NUM_PORTS-1:0]                  s_tvalid_i;
    logic [NUM_PORTS-1:0]                  s_tready_o;
    logic [AXI_WIDTH-1:0]                  m_tdata_o;
    logic [AXI_WIDTH/8-1:0]                m_tkeep_o;
    logic                                  m_tlast_o;
    logic [ID_W-1:0]                       m_tuser_o;
    logic                                  m_tvalid_o;
    logic                                  m_tready_i;

    modport master (
        input  s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i, m_tready_i,
        output s_tready_o, m_tdata_o, m_tkeep_o, m_tlast_o, m_tuser_o, m_tvalid_o
    );

    modport slave (
        output s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i, m_tready_i,
        input  s_tready_o, m_tdata_o, m_tkeep_o, m_tlast_o, m_tuser_o, m_tvalid_o
    );
endinterface

// File: rtl/packet_buffer_ingress_arbiter.sv
// Packet-granular round-robin merge of NUM_PORTS capture streams into packet_buffer,
// with id tagging and truncation (plus drain) of packets longer than MAX_BEATS.
module packet_buffer_ingress_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int AXI_WIDTH = 64,
    parameter int MAX_BEATS = 191,
    parameter int ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   enable_i,
    packet_buffer_ingress_arbiter_if.master        bus,
    output logic                                   busy_o,
    output logic                                   trunc_pulse_o,
    output logic [15:0]                            trunc_count_o
);

    localparam int KEEP_W = AXI_WIDTH / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PASS  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q;
    logic [ID_W-1:0]      grant_q;
    logic [ID_W-1:0]      last_grant_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [15:0]          trunc_cnt_q;
    logic                 trunc_pulse_q;

    logic [AXI_WIDTH-1:0] data_p0;
    logic [KEEP_W-1:0]    keep_p0;
    logic                 last_p0;
    logic [ID_W-1:0]      user_p0;
    logic                 vld_p0;

    logic                 load_en;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 at_limit;
    logic                 pass_acc;
    logic                 drain_acc;
    logic                 trunc_evt;
    logic                 found;
    logic [ID_W-1:0]      next_grant;
    logic [ID_W-1:0]      cand;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        load_en   = ~vld_p0 | bus.m_tready_i;
        sel_valid = bus.s_tvalid_i[grant_q];
        sel_last  = bus.s_tlast_i[grant_q];
        at_limit  = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
        pass_acc  = (state_q == ST_PASS) & load_en & sel_valid;
        drain_acc = (state_q == ST_DRAIN) & sel_valid;
        trunc_evt = pass_acc & ~sel_last & at_limit;
    end

    // Only the granted port is ever ready; a draining port is sunk without back-pressure.
    always_comb begin
        bus.s_tready_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.s_tready_o[p] = (ID_W'(p) == grant_q) &
                                (((state_q == ST_PASS) & load_en) | (state_q == ST_DRAIN));
        end
    end

    // Round-robin search starting just after the port that finished last.
    always_comb begin
        found      = 1'b0;
        next_grant = last_grant_q;
        cand       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = ID_W'((int'(last_grant_q) + 1 + i) % NUM_PORTS);
            if (!found && bus.s_tvalid_i[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Stage p0: output register toward packet_buffer, plus arbitration/packet FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= ID_W'(NUM_PORTS - 1);
            beat_cnt_q    <= '0;
            trunc_cnt_q   <= '0;
            trunc_pulse_q <= 1'b0;
            data_p0       <= '0;
            keep_p0       <= '0;
            last_p0       <= 1'b0;
            user_p0       <= '0;
            vld_p0        <= 1'b0;
        end else begin
            if (load_en) begin
                vld_p0 <= pass_acc;
                if (pass_acc) begin
                    data_p0 <= bus.s_tdata_i[grant_q];
                    keep_p0 <= bus.s_tkeep_i[grant_q];
                    last_p0 <= sel_last | at_limit;
                    user_p0 <= grant_q;
                end
            end

            trunc_pulse_q <= trunc_evt;
            if (trunc_evt) begin
                trunc_cnt_q <= sat_inc16(trunc_cnt_q);
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable_i && found) begin
                        grant_q <= next_grant;
                        state_q <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (pass_acc) begin
                        if (sel_last) begin
                            state_q      <= ST_IDLE;
                            last_grant_q <= grant_q;
                            beat_cnt_q   <= '0;
                        end else if (at_limit) begin
                            state_q    <= ST_DRAIN;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_acc && sel_last) begin
                        state_q      <= ST_IDLE;
                        last_grant_q <= grant_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_tdata_o  = data_p0;
    assign bus.m_tkeep_o  = keep_p0;
    assign bus.m_tlast_o  = last_p0;
    assign bus.m_tuser_o  = user_p0;
    assign bus.m_tvalid_o = vld_p0;
    assign busy_o         = (state_q != ST_IDLE);
    assign trunc_pulse_o  = trunc_pulse_q;
    assign trunc_count_o  = trunc_cnt_q;

endmodule
